// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the UART transmitter; issues one-cycle uart_tx_en pulses when the TX is idle.
// Optional sticky overflow flag enabled by defining UART_TX_FIFO_OVF_EN.
module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [7:0]                 wr_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       uart_tx_en,
    output logic [7:0]                 uart_tx_data,
    input  logic                       uart_tx_busy,
    output logic                       ovf,
    input  logic                       ovf_clr
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t         state, state_nxt;
    logic [7:0]     mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;
    logic           wr_ok, pop;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign level = count;
    assign wr_ok = wr_en && !full;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pop) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT: begin
                if (pop)               state_nxt = ISSUE;
                else if (!uart_tx_busy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pop decision; ISSUE never pops, which keeps uart_tx_en a single-cycle pulse
    always_comb begin
        pop = 1'b0;
        if ((state == IDLE || state == WAIT) && !empty && !uart_tx_busy)
            pop = 1'b1;
    end

    // Registered transmitter outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            uart_tx_en   <= 1'b0;
            uart_tx_data <= 8'h00;
        end else begin
            uart_tx_en <= pop;
            if (pop) uart_tx_data <= mem[rd_ptr];
        end
    end

    // Storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    // Set has priority over clear
    always_ff @(posedge clk) begin
        if (reset)              ovf <= 1'b0;
        else if (wr_en && full) ovf <= 1'b1;
        else if (ovf_clr)       ovf <= 1'b0;
    end
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based occupancy/issue model checked every cycle, plus directed literal checks.
// A simple transmitter model raises busy for 'frame' cycles after each accepted uart_tx_en.
module tb_uart_tx_fifo;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full, empty;
    logic [4:0] level;
    logic       uart_tx_en;
    logic [7:0] uart_tx_data;
    logic       uart_tx_busy;
    logic       ovf;
    logic       ovf_clr;

    logic       hold_busy;
    int         frame;
    int         tx_cnt;

    int checks = 0;
    int errors = 0;
    bit chk_on = 0;

    logic [7:0] m_q[$];
    logic       m_en;
    logic [7:0] m_data;
    logic       m_ovf;
    logic [7:0] log_q[$];

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .level(level),
        .uart_tx_en(uart_tx_en), .uart_tx_data(uart_tx_data), .uart_tx_busy(uart_tx_busy),
        .ovf(ovf), .ovf_clr(ovf_clr)
    );

    // Transmitter stand-in: busy the cycle after an accepted pulse, for 'frame' cycles
    always @(posedge clk) begin
        if (reset)            tx_cnt <= 0;
        else if (uart_tx_en)  tx_cnt <= frame;
        else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
    end
    assign uart_tx_busy = hold_busy || (tx_cnt != 0);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the FIFO is a queue; a byte is issued whenever data is queued, the
    // transmitter is not busy and no pulse is currently being presented.
    always @(negedge clk) begin
        bit pop, was_full;
        if (chk_on) begin
            chk("level", int'(level), m_q.size());
            chk("full",  int'(full),  int'(m_q.size() == DEPTH));
            chk("empty", int'(empty), int'(m_q.size() == 0));
            chk("tx_en", int'(uart_tx_en), int'(m_en));
            chk("tx_data", int'(uart_tx_data), int'(m_data));
            chk("ovf", int'(ovf), int'(m_ovf));
        end
        if (uart_tx_en === 1'b1) log_q.push_back(uart_tx_data);
        if (reset) begin
            m_q.delete();
            m_en = 0; m_data = 0; m_ovf = 0;
        end else begin
            was_full = (m_q.size() == DEPTH);
            pop = (m_q.size() > 0) && !uart_tx_busy && !m_en;
            if (pop) m_data = m_q.pop_front();
            m_en = pop;
            if (wr_en && !was_full) m_q.push_back(wr_data);
`ifdef UART_TX_FIFO_OVF_EN
            if (wr_en && was_full) m_ovf = 1;
            else if (ovf_clr)      m_ovf = 0;
`endif
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_drain(input string name);
        bit done = 0;
        for (int i = 0; i < 3000; i++) begin
            if (empty && !uart_tx_en && tx_cnt == 0) begin done = 1; break; end
            step();
        end
        chk({name, "_drain_timeout"}, int'(done), 1);
    endtask

    task automatic write_bytes(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            step(); wr_en = 1; wr_data = first + 8'(i);
        end
        step(); wr_en = 0;
    endtask

    initial begin
        reset = 1; wr_en = 0; wr_data = 0; ovf_clr = 0; hold_busy = 0; frame = 4;
        step(); step();
        chk_on = 1;
        step(); reset = 0;
        @(negedge clk);
        chk("rst_level", int'(level), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_en", int'(uart_tx_en), 0);
        chk("rst_data", int'(uart_tx_data), 0);
        chk("rst_ovf", int'(ovf), 0);

        // Single byte: pulse two cycles after the write
        step(); wr_en = 1; wr_data = 8'hA5;
        @(negedge clk); chk("sb_lvl0", int'(level), 0);
        step(); wr_en = 0;
        @(negedge clk); chk("sb_lvl1", int'(level), 1); chk("sb_en_n1", int'(uart_tx_en), 0);
        step();
        @(negedge clk);
        chk("sb_en_n2", int'(uart_tx_en), 1);
        chk("sb_data", int'(uart_tx_data), 8'hA5);
        chk("sb_lvl2", int'(level), 0);
        step();
        @(negedge clk); chk("sb_en_n3", int'(uart_tx_en), 0);
        wait_drain("sb");

        // Burst of four with a frame-length busy
        frame = 80; log_q.delete();
        write_bytes(8'h01, 4);
        wait_drain("burst");
        chk("burst_cnt", log_q.size(), 4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) chk("burst_order", int'(log_q[i]), i + 1);

        // Fill with busy held: 17 writes, last dropped
        frame = 4; hold_busy = 1;
        write_bytes(8'h80, 17);
        @(negedge clk);
        chk("full_lvl", int'(level), 16);
        chk("full_flag", int'(full), 1);
`ifdef UART_TX_FIFO_OVF_EN
        chk("full_ovf", int'(ovf), 1);
`else
        chk("full_ovf", int'(ovf), 0);
`endif
        step(); ovf_clr = 1;
        step(); ovf_clr = 0;
        @(negedge clk); chk("ovf_clr", int'(ovf), 0);

        // Write in the pop cycle while full is dropped
        log_q.delete();
        step(); hold_busy = 0; wr_en = 1; wr_data = 8'hEE;
        @(negedge clk); chk("sim_full", int'(full), 1);
        step(); wr_en = 0; hold_busy = 1;
        @(negedge clk); chk("sim_lvl15", int'(level), 15); chk("sim_en", int'(uart_tx_en), 1);
        hold_busy = 0;
        wait_drain("sim");
        chk("sim_cnt", log_q.size(), 16);
        for (int i = 0; i < 16 && i < log_q.size(); i++) chk("sim_order", int'(log_q[i]), 8'h80 + i);

        // Level 3: pop and write together keep level
        hold_busy = 1;
        write_bytes(8'h30, 3);
        @(negedge clk); chk("l3_pre", int'(level), 3);
        step(); hold_busy = 0; wr_en = 1; wr_data = 8'h33;
        @(negedge clk); chk("l3_same", int'(level), 3);
        step(); wr_en = 0;
        @(negedge clk); chk("l3_post", int'(level), 3); chk("l3_en", int'(uart_tx_en), 1);
        wait_drain("l3");

        // Wrap: 40 bytes in groups of 5
        frame = 3; log_q.delete();
        for (int g = 0; g < 8; g++) begin
            write_bytes(8'(8'h40 + g * 5), 5);
            wait_drain("wrap");
        end
        chk("wrap_cnt", log_q.size(), 40);
        for (int i = 0; i < 40 && i < log_q.size(); i++) chk("wrap_order", int'(log_q[i]), 8'h40 + i);

        // Reset during frame 2 of 4
        frame = 20; log_q.delete();
        write_bytes(8'hC0, 4);
        for (int i = 0; i < 500 && log_q.size() < 2; i++) step();
        chk("rst_mid_seen2", log_q.size(), 2);
        repeat (5) step();
        reset = 1;
        step(); reset = 0;
        @(negedge clk);
        chk("rm_level", int'(level), 0);
        chk("rm_en", int'(uart_tx_en), 0);
        chk("rm_line_idle", int'(uart_tx_busy), 0);
        repeat (200) step();
        chk("rm_no_more", log_q.size(), 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
